seq_compare: RTL and testbench

SEQ_COMPARE -- requirements
Module: seq_compare

---
 rtl/seq_compare_pkg.sv | 41 ++++
 rtl/seq_compare_chunk_compare.sv | 25 ++
 rtl/seq_compare.sv | 148 ++++++++++++++
 tb/tb_seq_compare.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_compare_pkg.sv
// rtl/seq_compare_pkg.sv - op encodings, FSM states and result selection for seq_compare
package seq_compare_pkg;

   // Comparison operations; LT/GE/LE are signed two's complement.
   typedef enum logic [2:0] {
      OP_EQ  = 3'd0,
      OP_NE  = 3'd1,
      OP_LT  = 3'd2,
      OP_GE  = 3'd3,
      OP_LTU = 3'd4,
      OP_GEU = 3'd5,
      OP_LE  = 3'd6,
      OP_LEU = 3'd7
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Signed ops need the sign bit of the top chunk flipped before an unsigned compare.
   function automatic logic is_signed_op(input logic [2:0] op);
      return (op == OP_LT) || (op == OP_GE) || (op == OP_LE);
   endfunction

   // Maps the first-difference flags onto the boolean outcome of op.
   function automatic logic op_result(input logic [2:0] op, input logic diff, input logic lt);
      logic r;
      case (op_t'(op))
         OP_EQ:          r = !diff;
         OP_NE:          r = diff;
         OP_LT, OP_LTU:  r = lt;
         OP_GE, OP_GEU:  r = !lt;
         OP_LE, OP_LEU:  r = lt | !diff;
         default:        r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/seq_compare_chunk_compare.sv
// rtl/seq_compare_chunk_compare.sv - combinational CHUNK-bit comparator with optional signed top chunk
module chunk_compare #(
   parameter int W = 8
) (
   input  logic [W-1:0] a_chunk,
   input  logic [W-1:0] b_chunk,
   input  logic         signed_top,
   output logic         eq,
   output logic         lt
);

   logic [W-1:0] top_mask;
   logic [W-1:0] a_m;
   logic [W-1:0] b_m;

   // Flipping the sign bit turns a signed compare into an unsigned one.
   always_comb begin
      top_mask = signed_top ? (W'(1) << (W - 1)) : '0;
      a_m      = a_chunk ^ top_mask;
      b_m      = b_chunk ^ top_mask;
      eq       = (a_chunk == b_chunk);
      lt       = (a_m < b_m);
   end

endmodule

// File: rtl/seq_compare.sv
// rtl/seq_compare.sv - chunk-serial MSB-first comparator; SEQ_COMPARE_EARLY_EXIT_EN enables early exit
module seq_compare
   import seq_compare_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             result
);

   localparam int N    = WIDTH / CHUNK;
   localparam int IDXW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDXW-1:0] IDX_TOP = IDXW'(N - 1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [2:0]       op_q;
   logic [IDXW-1:0]  idx;
   logic             diff;
   logic             lt;

   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK-1:0] b_chunk;
   logic             top_signed;
   logic             chunk_eq;
   logic             chunk_lt;
   logic             diff_new;
   logic             lt_new;
   logic             scan_last;

   assign a_chunk    = a_q[idx*CHUNK +: CHUNK];
   assign b_chunk    = b_q[idx*CHUNK +: CHUNK];
   assign top_signed = (idx == IDX_TOP) && is_signed_op(op_q);

   chunk_compare #(
      .W (CHUNK)
   ) u_chunk_compare (
      .a_chunk    (a_chunk),
      .b_chunk    (b_chunk),
      .signed_top (top_signed),
      .eq         (chunk_eq),
      .lt         (chunk_lt)
   );

   // First-difference flags including the chunk under comparison; earlier differences win.
   always_comb begin
      diff_new = diff | !chunk_eq;
      lt_new   = diff ? lt : (!chunk_eq & chunk_lt);
`ifdef SEQ_COMPARE_EARLY_EXIT_EN
      scan_last = (idx == '0) || !chunk_eq;
`else
      scan_last = (idx == '0);
`endif
   end

   // State register; reset wins over any request presented in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nxt = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (scan_last) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Operand capture, chunk walk and result register; result is cleared whenever not in DONE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= '0;
         idx    <= '0;
         diff   <= 1'b0;
         lt     <= 1'b0;
         result <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  a_q  <= a;
                  b_q  <= b;
                  op_q <= op;
                  idx  <= IDX_TOP;
                  diff <= 1'b0;
                  lt   <= 1'b0;
               end
            end
            ST_SCAN: begin
               diff <= diff_new;
               lt   <= lt_new;
               if (scan_last) begin
                  result <= op_result(op_q, diff_new, lt_new);
               end else begin
                  idx <= idx - IDXW'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  result <= 1'b0;
               end
            end
            default: begin
               result <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_compare.sv
// tb/tb_seq_compare.sv - self-checking bench for seq_compare (table vectors, corner sequences, random vs model)
module tb_seq_compare;

   localparam int WIDTH = 32;
   localparam int CHUNK = 8;
   localparam int N     = WIDTH / CHUNK;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic             result;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seq_compare #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   typedef struct {
      logic [31:0] va;
      logic [31:0] vb;
      logic [2:0]  vop;
      logic        exp;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: full-width arithmetic comparison.
   function automatic logic model_res(input logic [31:0] x, input logic [31:0] y, input logic [2:0] o);
      case (o)
         3'd0: return x == y;
         3'd1: return x != y;
         3'd2: return $signed(x) < $signed(y);
         3'd3: return $signed(x) >= $signed(y);
         3'd4: return x < y;
         3'd5: return x >= y;
         3'd6: return $signed(x) <= $signed(y);
         default: return x <= y;
      endcase
   endfunction

   // Reference latency in cycles from the accept cycle to the first out_valid cycle.
   function automatic int model_lat(input logic [31:0] x, input logic [31:0] y);
`ifdef SEQ_COMPARE_EARLY_EXIT_EN
      for (int k = 1; k <= N; k++) begin
         if (x[WIDTH-k*CHUNK +: CHUNK] != y[WIDTH-k*CHUNK +: CHUNK]) return k + 1;
      end
      return N + 1;
`else
      if (x == y) return N + 1;
      return N + 1;
`endif
   endfunction

   task automatic run_req(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] top,
                          input int hold, output logic res, output int lat,
                          output logic hold_ok, output logic idle_ok);
      int w;
      hold_ok = 1'b1;
      idle_ok = 1'b1;
      w = 0;
      while (!in_ready && w < 50) begin
         step();
         w++;
      end
      a = ta;
      b = tb;
      op = top;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
      op = 3'($urandom);
      lat = 1;
      while (!out_valid && lat < 64) begin
         if (result !== 1'b0 || in_ready) idle_ok = 1'b0;
         step();
         lat++;
      end
      res = result;
      for (int i = 0; i < hold; i++) begin
         step();
         if (!out_valid || in_ready || result !== res) hold_ok = 1'b0;
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      if (!in_ready || out_valid || result !== 1'b0) idle_ok = 1'b0;
   endtask

   initial begin
      logic        res;
      int          lat;
      logic        hold_ok;
      logic        idle_ok;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [2:0]  rop;
      int          mode;

      vecs[0]  = '{32'hFFFFFFFF, 32'h00000001, 3'd2, 1'b1};
      vecs[1]  = '{32'hFFFFFFFF, 32'h00000001, 3'd4, 1'b0};
      vecs[2]  = '{32'hFFFFFFFF, 32'h00000001, 3'd5, 1'b1};
      vecs[3]  = '{32'h12345678, 32'h12345678, 3'd0, 1'b1};
      vecs[4]  = '{32'h12345678, 32'h12345678, 3'd6, 1'b1};
      vecs[5]  = '{32'h12345678, 32'h12345678, 3'd3, 1'b1};
      vecs[6]  = '{32'h12345678, 32'h12345678, 3'd1, 1'b0};
      vecs[7]  = '{32'h80000000, 32'h00000000, 3'd2, 1'b1};
      vecs[8]  = '{32'h80000000, 32'h00000000, 3'd4, 1'b0};
      vecs[9]  = '{32'h7FFFFFFF, 32'h80000000, 3'd3, 1'b1};
      vecs[10] = '{32'h00000100, 32'h000000FF, 3'd7, 1'b0};
      vecs[11] = '{32'h000000FF, 32'h00000100, 3'd6, 1'b1};
      vecs[12] = '{32'h12345678, 32'h12345679, 3'd2, 1'b1};
      vecs[13] = '{32'hFFFFFF00, 32'hFFFFFFFF, 3'd5, 1'b0};

      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      op = '0;
      step();
      step();
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_result", 32'(result), 32'd0);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 14; i++) begin
         run_req(vecs[i].va, vecs[i].vb, vecs[i].vop, 0, res, lat, hold_ok, idle_ok);
         check($sformatf("vec%0d_result", i), 32'(res), 32'(vecs[i].exp));
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(model_lat(vecs[i].va, vecs[i].vb)));
         check($sformatf("vec%0d_idle", i), 32'(idle_ok), 32'd1);
      end

      // DONE held for 10 cycles with out_ready low.
      run_req(32'hFFFFFFFF, 32'h00000001, 3'd2, 10, res, lat, hold_ok, idle_ok);
      check("hold_result", 32'(res), 32'd1);
      check("hold_stable", 32'(hold_ok), 32'd1);

      // Reset asserted mid-SCAN discards the request.
      a = 32'h00000001;
      b = 32'h00000002;
      op = 3'd4;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("midscan_rst_in_ready", 32'(in_ready), 32'd1);
      check("midscan_rst_out_valid", 32'(out_valid), 32'd0);
      check("midscan_rst_result", 32'(result), 32'd0);
      run_req(32'h00000005, 32'h00000003, 3'd3, 0, res, lat, hold_ok, idle_ok);
      check("after_rst_result", 32'(res), 32'd1);
      check("after_rst_latency", 32'(lat), 32'(model_lat(32'h5, 32'h3)));

      // Request presented during reset is not taken.
      a = 32'h1;
      b = 32'h1;
      op = 3'd0;
      in_valid = 1'b1;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      in_valid = 1'b0;
      check("rst_req_ignored", 32'(in_ready), 32'd1);
      step();
      check("rst_req_no_valid", 32'(out_valid), 32'd0);

      // Randomised requests against the reference model.
      for (int i = 0; i < 150; i++) begin
         ra = $urandom;
         mode = $urandom_range(0, 2);
         if (mode == 0) rb = ra;
         else if (mode == 1) rb = ra ^ (32'($urandom_range(1, 255)) << (8 * $urandom_range(0, 3)));
         else rb = $urandom;
         rop = 3'($urandom_range(0, 7));
         run_req(ra, rb, rop, $urandom_range(0, 2), res, lat, hold_ok, idle_ok);
         check($sformatf("rand%0d_result a=%0h b=%0h op=%0d", i, ra, rb, rop), 32'(res), 32'(model_res(ra, rb, rop)));
         check($sformatf("rand%0d_latency", i), 32'(lat), 32'(model_lat(ra, rb)));
         check($sformatf("rand%0d_handshake", i), 32'(idle_ok & hold_ok), 32'd1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
